// File: rtl/ycbcr_pkg.sv
// Shared definitions for the YCbCr chroma resampling blocks: the pixel-pair
// phase used by the 4:4:4 -> 4:2:2 subsampler and the chroma-select encoding
// carried alongside every 4:2:2 chroma sample.
package ycbcr_pkg;

    // Position of the next accepted pixel within its horizontal pair.
    typedef enum logic {
        PH_EVEN = 1'b0,
        PH_ODD  = 1'b1
    } phase_t;

    // Chroma-select flag values for a 4:2:2 chroma sample.
    localparam logic C_IS_CB = 1'b0;
    localparam logic C_IS_CR = 1'b1;

endpackage

// File: rtl/ycbcr444to422_chroma_avg.sv
// Combinational rounded average of two chroma samples: (a + b + 1) >> 1.
// The sum is formed one bit wider than the inputs, so the halved result
// always fits back into BIT_WIDTH bits.
module chroma_avg #(
    parameter int BIT_WIDTH = 8
) (
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    output logic [BIT_WIDTH-1:0] avg
);

    // Widen, add with round-half-up, then drop the LSB back to sample width.
    assign avg = BIT_WIDTH'(({1'b0, a} + {1'b0, b} + (BIT_WIDTH + 1)'(1)) >> 1);

endmodule

// File: rtl/ycbcr444to422.sv
// Streaming 4:4:4 -> 4:2:2 chroma subsampler. Horizontally adjacent pixels
// are paired; the first output of a pair carries the averaged Cb, the second
// the averaged Cr. A lone pixel at the end of an odd-length line is sent on
// with its own Cb and its Cr dropped. No backpressure: one pixel per clock.
module ycbcr444to422
    import ycbcr_pkg::*;
#(
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 n_rst,
    input  logic                 in_valid,
    input  logic                 in_eol,
    input  logic [BIT_WIDTH-1:0] in_y,
    input  logic [BIT_WIDTH-1:0] in_cb,
    input  logic [BIT_WIDTH-1:0] in_cr,
    output logic                 out_valid,
    output logic                 out_eol,
    output logic [BIT_WIDTH-1:0] out_y,
    output logic [BIT_WIDTH-1:0] out_c,
    output logic                 out_c_is_cr
);

    phase_t phase;

    // Pixel A, held while waiting for its partner.
    logic [BIT_WIDTH-1:0] hold_y;
    logic [BIT_WIDTH-1:0] hold_cb;
    logic [BIT_WIDTH-1:0] hold_cr;

    // Second output of a pair (or an odd tail), emitted one cycle later.
    logic                 pend_valid;
    logic                 pend_eol;
    logic                 pend_is_cr;
    logic [BIT_WIDTH-1:0] pend_y;
    logic [BIT_WIDTH-1:0] pend_c;

    logic [BIT_WIDTH-1:0] avg_cb;
    logic [BIT_WIDTH-1:0] avg_cr;

    logic accept_a;
    logic accept_b;
    logic accept_tail;

    chroma_avg #(.BIT_WIDTH(BIT_WIDTH)) u_avg_cb (
        .a   (hold_cb),
        .b   (in_cb),
        .avg (avg_cb)
    );

    chroma_avg #(.BIT_WIDTH(BIT_WIDTH)) u_avg_cr (
        .a   (hold_cr),
        .b   (in_cr),
        .avg (avg_cr)
    );

    // Classify the current input by pair position.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        accept_a    = 1'b0;
        accept_b    = 1'b0;
        accept_tail = 1'b0;
        if (in_valid) begin
            if (phase == PH_ODD) begin
                accept_b = 1'b1;
            end else if (in_eol) begin
                accept_tail = 1'b1;
            end else begin
                accept_a = 1'b1;
            end
        end
    end

    // Phase FSM: an A moves to ODD; a B or a tail leaves the phase at EVEN,
    // so every line starts on Cb.
    always_ff @(posedge clock or negedge n_rst) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from pre-edge values.
        if (!n_rst) begin
            phase <= PH_EVEN;
        end else if (accept_a) begin
            phase <= PH_ODD;
        end else if (accept_b) begin
            phase <= PH_EVEN;
        end
    end

    // Held-pixel register captures pixel A.
    always_ff @(posedge clock or negedge n_rst) begin
        // NOTE: held data is cleared on reset so nothing captured before reset
        // can ever be paired with post-reset pixels.
        if (!n_rst) begin
            hold_y  <= '0;
            hold_cb <= '0;
            hold_cr <= '0;
        end else if (accept_a) begin
            hold_y  <= in_y;
            hold_cb <= in_cb;
            hold_cr <= in_cr;
        end
    end

    // Pending register: the Cr half of a pair, or an odd tail with its raw Cb.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            pend_valid <= 1'b0;
            pend_eol   <= 1'b0;
            pend_is_cr <= C_IS_CB;
            pend_y     <= '0;
            pend_c     <= '0;
        end else begin
            pend_valid <= accept_b || accept_tail;
            if (accept_b) begin
                pend_eol   <= in_eol;
                pend_is_cr <= C_IS_CR;
                pend_y     <= in_y;
                pend_c     <= avg_cr;
            end else if (accept_tail) begin
                pend_eol   <= 1'b1;
                pend_is_cr <= C_IS_CB;
                pend_y     <= in_y;
                pend_c     <= in_cb;
            end
        end
    end

    // Output stage: a completed pair sends A with averaged Cb immediately;
    // otherwise the pending entry drains. A new pair can never complete in
    // the same cycle the pending entry is full, so the two never collide.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            out_valid   <= 1'b0;
            out_eol     <= 1'b0;
            out_y       <= '0;
            out_c       <= '0;
            out_c_is_cr <= C_IS_CB;
        end else if (accept_b) begin
            out_valid   <= 1'b1;
            out_eol     <= 1'b0;
            out_y       <= hold_y;
            out_c       <= avg_cb;
            out_c_is_cr <= C_IS_CB;
        end else if (pend_valid) begin
            out_valid   <= 1'b1;
            out_eol     <= pend_eol;
            out_y       <= pend_y;
            out_c       <= pend_c;
            out_c_is_cr <= pend_is_cr;
        end else begin
            out_valid   <= 1'b0;
            out_eol     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ycbcr444to422.sv
// Self-checking bench for ycbcr444to422 (BIT_WIDTH = 8). A pixel-level model
// schedules the expected output of every accepted pixel at an absolute cycle;
// one compare process checks the DUT against that schedule every cycle, and a
// few hand-computed literals pin the model at directed points.
module tb_ycbcr444to422;

    typedef struct {
        logic [7:0] y;
        logic [7:0] c;
        logic       is_cr;
        logic       eol;
    } out_t;

    logic       clock;
    logic       n_rst;
    logic       in_valid;
    logic       in_eol;
    logic [7:0] in_y;
    logic [7:0] in_cb;
    logic [7:0] in_cr;
    logic       out_valid;
    logic       out_eol;
    logic [7:0] out_y;
    logic [7:0] out_c;
    logic       out_c_is_cr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit run      = 1'b0;

    // Model state: expected outputs keyed by cycle, plus literal pins.
    out_t exp_q[int];
    out_t lit_q[int];
    bit         have_a = 1'b0;
    logic [7:0] a_y, a_cb, a_cr;

    ycbcr444to422 #(.BIT_WIDTH(8)) dut (
        .clock       (clock),
        .n_rst       (n_rst),
        .in_valid    (in_valid),
        .in_eol      (in_eol),
        .in_y        (in_y),
        .in_cb       (in_cb),
        .in_cr       (in_cr),
        .out_valid   (out_valid),
        .out_eol     (out_eol),
        .out_y       (out_y),
        .out_c       (out_c),
        .out_c_is_cr (out_c_is_cr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = (int'(a) + int'(b) + 1) / 2;
        return s[7:0];
    endfunction

    function automatic logic [31:0] pack(input logic v, input out_t o);
        return {13'd0, v, o.y, o.c, o.is_cr, o.eol};
    endfunction

    task automatic sched(input int k, input out_t o);
        if (exp_q.exists(k)) begin
            checks++;
            failures++;
            $display("FAIL model_slot_collision cyc=%0d slot=%0d", cyc, k);
        end
        exp_q[k] = o;
    endtask

    // Model of one accepted pixel during the current cycle.
    task automatic model_accept(input bit e, input logic [7:0] y, input logic [7:0] cb,
                                input logic [7:0] cr);
        out_t o;
        if (have_a) begin
            o.y = a_y; o.c = avg8(a_cb, cb); o.is_cr = 1'b0; o.eol = 1'b0;
            sched(cyc + 1, o);
            o.y = y;   o.c = avg8(a_cr, cr); o.is_cr = 1'b1; o.eol = e;
            sched(cyc + 2, o);
            have_a = 1'b0;
        end else if (e) begin
            o.y = y; o.c = cb; o.is_cr = 1'b0; o.eol = 1'b1;
            sched(cyc + 2, o);
        end else begin
            have_a = 1'b1;
            a_y = y; a_cb = cb; a_cr = cr;
        end
    endtask

    // Drive one cycle of input, update the model, advance to the next cycle.
    task automatic drive(input bit v, input bit e, input logic [7:0] y,
                         input logic [7:0] cb, input logic [7:0] cr);
        in_valid = v; in_eol = e; in_y = y; in_cb = cb; in_cr = cr;
        if (n_rst && v) model_accept(e, y, cb, cr);
        @(posedge clock); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic set_reset(input bit level);
        n_rst = level;
        if (!level) begin
            have_a = 1'b0;
            exp_q.delete();
            lit_q.delete();
        end
    endtask

    task automatic expect_lit(input int k, input logic [7:0] y, input logic [7:0] c,
                              input logic is_cr, input logic eol);
        out_t o;
        o.y = y; o.c = c; o.is_cr = is_cr; o.eol = eol;
        lit_q[k] = o;
    endtask

    // Single compare process, mid-cycle on the falling edge.
    always @(negedge clock) begin
        if (run) begin
            if (!n_rst) begin
                check("reset_outputs", {13'd0, out_valid, out_y, out_c, out_c_is_cr, out_eol}, 32'd0);
            end else if (exp_q.exists(cyc)) begin
                check("stream_output", {13'd0, out_valid, out_y, out_c, out_c_is_cr, out_eol},
                      pack(1'b1, exp_q[cyc]));
                if (lit_q.exists(cyc)) begin
                    check("model_pin", pack(1'b1, exp_q[cyc]), pack(1'b1, lit_q[cyc]));
                    check("literal_output", {13'd0, out_valid, out_y, out_c, out_c_is_cr, out_eol},
                          pack(1'b1, lit_q[cyc]));
                    lit_q.delete(cyc);
                end
                exp_q.delete(cyc);
            end else begin
                check("idle_valid", {31'd0, out_valid}, 32'd0);
                if (lit_q.exists(cyc)) begin
                    check("model_pin_missing", 32'd0, 32'd1);
                    lit_q.delete(cyc);
                end
            end
        end
    end

    initial begin
        int t0;
        n_rst = 1'b0;
        in_valid = 1'b0; in_eol = 1'b0; in_y = '0; in_cb = '0; in_cr = '0;
        run = 1'b1;

        // 1: reset held with random valid inputs, then idle.
        for (int i = 0; i < 4; i++)
            drive(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        set_reset(1'b1);
        idle(5);

        // 2: basic pair, B carries eol.
        t0 = cyc;
        drive(1'b1, 1'b0, 8'd10, 8'd100, 8'd200);
        drive(1'b1, 1'b1, 8'd20, 8'd103, 8'd50);
        expect_lit(t0 + 2, 8'd10, 8'd102, 1'b0, 1'b0);
        expect_lit(t0 + 3, 8'd20, 8'd125, 1'b1, 1'b1);
        idle(4);

        // 3: 3-pixel line with odd tail, then next line starts on Cb.
        t0 = cyc;
        drive(1'b1, 1'b0, 8'd1, 8'd40, 8'd10);
        drive(1'b1, 1'b0, 8'd2, 8'd42, 8'd12);
        drive(1'b1, 1'b1, 8'd3, 8'd77, 8'd99);
        drive(1'b1, 1'b0, 8'd4, 8'd1, 8'd5);
        drive(1'b1, 1'b1, 8'd5, 8'd3, 8'd7);
        expect_lit(t0 + 2, 8'd1, 8'd41, 1'b0, 1'b0);
        expect_lit(t0 + 3, 8'd2, 8'd11, 1'b1, 1'b0);
        expect_lit(t0 + 4, 8'd3, 8'd77, 1'b0, 1'b1);
        expect_lit(t0 + 5, 8'd4, 8'd2, 1'b0, 1'b0);
        expect_lit(t0 + 6, 8'd5, 8'd6, 1'b1, 1'b1);
        idle(4);

        // 4: gap of three invalid cycles between A and B.
        t0 = cyc;
        drive(1'b1, 1'b0, 8'd30, 8'd8, 8'd9);
        idle(3);
        drive(1'b1, 1'b1, 8'd31, 8'd10, 8'd11);
        expect_lit(t0 + 5, 8'd30, 8'd9, 1'b0, 1'b0);
        expect_lit(t0 + 6, 8'd31, 8'd10, 1'b1, 1'b1);
        idle(4);

        // 5: extremes, no wrap.
        t0 = cyc;
        drive(1'b1, 1'b0, 8'd255, 8'd255, 8'd0);
        drive(1'b1, 1'b0, 8'd0, 8'd255, 8'd0);
        drive(1'b1, 1'b0, 8'd7, 8'd0, 8'd254);
        drive(1'b1, 1'b1, 8'd8, 8'd1, 8'd255);
        expect_lit(t0 + 2, 8'd255, 8'd255, 1'b0, 1'b0);
        expect_lit(t0 + 3, 8'd0, 8'd0, 1'b1, 1'b0);
        expect_lit(t0 + 4, 8'd7, 8'd1, 1'b0, 1'b0);
        expect_lit(t0 + 5, 8'd8, 8'd255, 1'b1, 1'b1);
        idle(4);

        // 6: reset while A is held; A must never appear.
        drive(1'b1, 1'b0, 8'd99, 8'd99, 8'd99);
        set_reset(1'b0);
        idle(2);
        set_reset(1'b1);
        idle(1);
        t0 = cyc;
        drive(1'b1, 1'b0, 8'd50, 8'd20, 8'd30);
        drive(1'b1, 1'b1, 8'd51, 8'd23, 8'd33);
        expect_lit(t0 + 2, 8'd50, 8'd22, 1'b0, 1'b0);
        expect_lit(t0 + 3, 8'd51, 8'd32, 1'b1, 1'b1);
        idle(4);

        // Randomized stream with gaps, random line lengths and rare resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                set_reset(1'b0);
                idle(2);
                set_reset(1'b1);
            end else begin
                drive($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0,
                      8'($urandom), 8'($urandom), 8'($urandom));
            end
        end
        idle(5);

        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ycbcr444to422.md
Name: ycbcr444to422

Overview:
Streaming 4:4:4 to 4:2:2 chroma subsampler that sits directly downstream of the RGB-to-YCbCr converter in the image_processor pipeline. It pairs horizontally adjacent pixels and averages their Cb and Cr with rounding. It emits one Y per pixel, plus one chroma sample that alternates Cb (even pixel) and Cr (odd pixel). The block is free-running with a valid qualifier and no backpressure, matching the rest of the pixel pipeline.

Parameters:
BIT_WIDTH, 8, bit width of each Y/Cb/Cr component on input and output.

Ports:
clock  in  1  pipeline clock; all logic is on the rising edge.
n_rst  in  1  asynchronous active-low reset.
in_valid  in  1  input pixel qualifier; may drop low on any cycle.
in_eol  in  1  last pixel of the line; only meaningful when in_valid=1.
in_y  in  BIT_WIDTH  luma.
in_cb  in  BIT_WIDTH  blue-difference chroma, full scale.
in_cr  in  BIT_WIDTH  red-difference chroma, full scale.
out_valid  out  1  output pixel qualifier.
out_eol  out  1  last output pixel of the line.
out_y  out  BIT_WIDTH  luma, unmodified from input.
out_c  out  BIT_WIDTH  subsampled chroma (Cb or Cr).
out_c_is_cr  out  1  0 when out_c carries Cb, 1 when it carries Cr.

Behaviour:
- Reset: one clock, asynchronous active-low (n_rst); reset is asynchronous, deassertion is synchronized externally.
  - While n_rst=0, all outputs are 0 and phase = EVEN.
  - Held-pixel and pending-output registers are cleared; held data is discarded, never emitted.
- Phase state machine (2 states):
  - EVEN: a valid input with in_eol=0 is stored as pixel A; go to ODD.
  - EVEN: a valid input with in_eol=1 (odd-length tail) schedules a tail output; stay in EVEN.
  - ODD: a valid input becomes pixel B; go to EVEN, regardless of in_eol.
  - in_valid=0: no state change and no data capture.
- Averaging: avg = (a + b + 1) >> 1, computed with one extra bit of headroom. The result always fits in BIT_WIDTH and never overflows.
- Output timing, relative to the cycle t in which B is accepted:
  - t+1: out_valid=1, out_y=A.y, out_c=avg(A.cb,B.cb), out_c_is_cr=0, out_eol=0.
  - t+2: out_valid=1, out_y=B.y, out_c=avg(A.cr,B.cr), out_c_is_cr=1, out_eol=B.eol.
  - A second output register holds B so that back-to-back inputs never collide. For a gap-free stream, every pixel appears exactly 2 cycles after it is accepted.
- Odd tail pixel accepted at cycle t:
  - Emitted at t+2 with out_y=tail.y, out_c=tail.cb (no averaging), out_c_is_cr=0, out_eol=1.
  - Its Cr is dropped.
  - Ordering is preserved because the previous B output occurs no later than t+1.
- Throughput: one input per cycle sustained. out_valid is low on every cycle with no scheduled output.
- out_eol is asserted only on the final output of a line. in_eol always returns the phase to EVEN, so every line starts with Cb.
- No internal frame handling. A frame boundary without a preceding eol is an upstream protocol violation; behaviour is to continue pairing.

Decomposition:
- Shared package ycbcr_pkg:
  - phase_t enum {PH_EVEN, PH_ODD}.
  - Chroma-select constants C_IS_CB=1'b0 and C_IS_CR=1'b1, reused by the future 4:2:2 to 4:4:4 upsampler.
- One sub-module, chroma_avg: BIT_WIDTH-parameterized combinational rounded average of two samples, instantiated twice (Cb, Cr).
- Top level contains the phase FSM, held-pixel register, B output register and output stage. Target size is about 150-200 lines.

Test Plan:
All scenarios use BIT_WIDTH=8.
1. Hold n_rst=0 with random inputs -> all outputs 0. Release, then idle 5 cycles -> out_valid stays 0.
2. A(y=10,cb=100,cr=200) at t0, then B(y=20,cb=103,cr=50,eol=1) at t1 -> t2: y=10, c=102, is_cr=0, eol=0; t3: y=20, c=125, is_cr=1, eol=1.
3. Continuous 3-pixel line with cb=40,42,77 and cr=10,12,99, eol on pixel 3 -> outputs c=41 (Cb), 11 (Cr), 77 (Cb, eol=1). The next line's first output is Cb.
4. A at t0, in_valid=0 for t1-t3, B at t4 -> A out at t5, B out at t6, out_valid=0 at t1-t4.
5. Extremes: cb 255/255 -> 255; cb 0/1 -> 1; cr 254/255 -> 255; no wrap.
6. Assert n_rst=0 at t1 after A is accepted at t0, release at t3, then send C(eol=0) and D(eol=1) -> A is never emitted, and C/D pair correctly with C as Cb.
